mem_wb_stage: RTL and testbench

//  MEM/WB pipeline register of the 5-stage core; feeds the 8:1 writeback-select mux.
//  - Captures MEM-stage results and aligns/extends load data.
//  - Registers the 3-bit writeback-source select and gates the register-file write enable.
//  - Keeps a retired-instruction counter.

---
 rtl/mem_wb_stage_pkg.sv | 24 ++
 rtl/mem_wb_stage_load_align.sv | 30 +++
 rtl/mem_wb_stage.sv | 135 +++++++++++++
 tb/tb_mem_wb_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - writeback-source and load-size codes for the MEM/WB stage
package mem_wb_stage_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'd0,
    WB_LOAD  = 3'd1,
    WB_PC4   = 3'd2,
    WB_IMM   = 3'd3,
    WB_AUIPC = 3'd4
  } wb_src_e;

  localparam logic [2:0] WB_SRC_MAX = 3'd4;

  typedef enum logic [1:0] {
    LS_B = 2'd0,
    LS_H = 2'd1,
    LS_W = 2'd2
  } ld_size_e;

  function automatic logic wb_src_legal(input logic [2:0] src);
    return src <= WB_SRC_MAX;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - selects the addressed byte/half of a load word and extends it
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [1:0]      size,
  input  logic            ld_unsigned,
  output logic [XLEN-1:0] aligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Half loads use only the upper offset bit; misaligned halves read the containing lane.
  assign byte_lane = rdata[8*addr_lo +: 8];
  assign half_lane = rdata[16*addr_lo[1] +: 16];

  always_comb begin
    aligned = rdata;
    case (size)
      LS_B:    aligned = {{(XLEN-8){~ld_unsigned & byte_lane[7]}}, byte_lane};
      LS_H:    aligned = {{(XLEN-16){~ld_unsigned & half_lane[15]}}, half_lane};
      default: aligned = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load alignment and retire counter
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               mem_valid,
  input  logic [RADDR_W-1:0] mem_rd,
  input  logic               mem_reg_write,
  input  logic [2:0]         mem_wb_src,
  input  logic [XLEN-1:0]    mem_alu,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic [1:0]         mem_addr_lo,
  input  logic [1:0]         mem_ld_size,
  input  logic               mem_ld_unsigned,
  input  logic [XLEN-1:0]    mem_pc4,
  input  logic [XLEN-1:0]    mem_imm,
  input  logic [XLEN-1:0]    mem_auipc,
  output logic               wb_valid,
  output logic [RADDR_W-1:0] wb_rd,
  output logic               wb_reg_write,
  output logic [2:0]         wb_sel,
  output logic [XLEN-1:0]    wb_alu,
  output logic [XLEN-1:0]    wb_load,
  output logic [XLEN-1:0]    wb_pc4,
  output logic [XLEN-1:0]    wb_imm,
  output logic [XLEN-1:0]    wb_auipc,
  output logic               wb_illegal,
  output logic [CNT_W-1:0]   retired_cnt
);

  logic               valid_q, valid_d;
  logic [RADDR_W-1:0] rd_q, rd_d;
  logic               reg_write_q, reg_write_d;
  logic [2:0]         sel_q, sel_d;
  logic [XLEN-1:0]    alu_q, alu_d;
  logic [XLEN-1:0]    load_q, load_d;
  logic [XLEN-1:0]    pc4_q, pc4_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic [XLEN-1:0]    auipc_q, auipc_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [XLEN-1:0]    load_aligned;
  logic               src_legal;

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata       (mem_rdata),
    .addr_lo     (mem_addr_lo),
    .size        (mem_ld_size),
    .ld_unsigned (mem_ld_unsigned),
    .aligned     (load_aligned)
  );

  assign src_legal = wb_src_legal(mem_wb_src);

  always_comb begin
    valid_d     = valid_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    sel_d       = sel_q;
    alu_d       = alu_q;
    load_d      = load_q;
    pc4_d       = pc4_q;
    imm_d       = imm_q;
    auipc_d     = auipc_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    // Flush only kills the control bits; data and select are left as-is.
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      valid_d     = mem_valid;
      rd_d        = mem_rd;
      reg_write_d = mem_valid & mem_reg_write & (mem_rd != '0) & src_legal;
      sel_d       = src_legal ? mem_wb_src : WB_ALU;
      alu_d       = mem_alu;
      load_d      = load_aligned;
      pc4_d       = mem_pc4;
      imm_d       = mem_imm;
      auipc_d     = mem_auipc;
      illegal_d   = mem_valid & ~src_legal;
      if (mem_valid) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      sel_q       <= '0;
      alu_q       <= '0;
      load_q      <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      auipc_q     <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      sel_q       <= sel_d;
      alu_q       <= alu_d;
      load_q      <= load_d;
      pc4_q       <= pc4_d;
      imm_q       <= imm_d;
      auipc_q     <= auipc_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign wb_valid     = valid_q;
  assign wb_rd        = rd_q;
  assign wb_reg_write = reg_write_q;
  assign wb_sel       = sel_q;
  assign wb_alu       = alu_q;
  assign wb_load      = load_q;
  assign wb_pc4       = pc4_q;
  assign wb_imm       = imm_q;
  assign wb_auipc     = auipc_q;
  assign wb_illegal   = illegal_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized bench for mem_wb_stage against a behavioural model
module tb_mem_wb_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n, stall, flush;
  logic               mem_valid, mem_reg_write, mem_ld_unsigned;
  logic [RADDR_W-1:0] mem_rd;
  logic [2:0]         mem_wb_src;
  logic [XLEN-1:0]    mem_alu, mem_rdata, mem_pc4, mem_imm, mem_auipc;
  logic [1:0]         mem_addr_lo, mem_ld_size;
  logic               wb_valid, wb_reg_write, wb_illegal;
  logic [RADDR_W-1:0] wb_rd;
  logic [2:0]         wb_sel;
  logic [XLEN-1:0]    wb_alu, wb_load, wb_pc4, wb_imm, wb_auipc;
  logic [CNT_W-1:0]   retired_cnt;

  mem_wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_wb_src(mem_wb_src), .mem_alu(mem_alu), .mem_rdata(mem_rdata),
    .mem_addr_lo(mem_addr_lo), .mem_ld_size(mem_ld_size),
    .mem_ld_unsigned(mem_ld_unsigned), .mem_pc4(mem_pc4), .mem_imm(mem_imm),
    .mem_auipc(mem_auipc), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_sel(wb_sel), .wb_alu(wb_alu),
    .wb_load(wb_load), .wb_pc4(wb_pc4), .wb_imm(wb_imm), .wb_auipc(wb_auipc),
    .wb_illegal(wb_illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs
  logic        e_valid, e_rw, e_ill;
  logic [4:0]  e_rd;
  logic [2:0]  e_sel;
  logic [31:0] e_alu, e_load, e_pc4, e_imm, e_auipc;
  int          e_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input int lo, input int sz,
                                           input bit uns);
    longint v;
    if (sz == 0) begin
      v = (w >> (8 * lo)) % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = (w >> (16 * (lo / 2))) % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return 32'(v);
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      e_valid = 0; e_rw = 0; e_ill = 0; e_rd = 0; e_sel = 0;
      e_alu = 0; e_load = 0; e_pc4 = 0; e_imm = 0; e_auipc = 0; e_cnt = 0;
    end else if (flush) begin
      e_valid = 0; e_rw = 0; e_ill = 0;
    end else if (!stall) begin
      e_valid = mem_valid;
      e_rd    = mem_rd;
      e_rw    = mem_valid && mem_reg_write && mem_rd != 0 && mem_wb_src <= 4;
      e_ill   = mem_valid && mem_wb_src > 4;
      e_sel   = (mem_wb_src <= 4) ? mem_wb_src : 3'd0;
      e_alu   = mem_alu;
      e_load  = ref_load(mem_rdata, int'(mem_addr_lo), int'(mem_ld_size), mem_ld_unsigned);
      e_pc4   = mem_pc4;
      e_imm   = mem_imm;
      e_auipc = mem_auipc;
      if (mem_valid) e_cnt = (e_cnt + 1) % (1 << CNT_W);
    end
  endtask

  task automatic compare_all();
    check("wb_valid", 64'(wb_valid), 64'(e_valid));
    check("wb_rd", 64'(wb_rd), 64'(e_rd));
    check("wb_reg_write", 64'(wb_reg_write), 64'(e_rw));
    check("wb_sel", 64'(wb_sel), 64'(e_sel));
    check("wb_alu", 64'(wb_alu), 64'(e_alu));
    check("wb_load", 64'(wb_load), 64'(e_load));
    check("wb_pc4", 64'(wb_pc4), 64'(e_pc4));
    check("wb_imm", 64'(wb_imm), 64'(e_imm));
    check("wb_auipc", 64'(wb_auipc), 64'(e_auipc));
    check("wb_illegal", 64'(wb_illegal), 64'(e_ill));
    check("retired_cnt", 64'(retired_cnt), 64'(e_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic rand_inputs();
    mem_valid       = ($urandom_range(0, 3) != 0);
    mem_rd          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    mem_reg_write   = 1'($urandom);
    mem_wb_src      = 3'($urandom);
    mem_alu         = $urandom;
    mem_rdata       = $urandom;
    mem_addr_lo     = 2'($urandom);
    mem_ld_size     = 2'($urandom);
    mem_ld_unsigned = 1'($urandom);
    mem_pc4         = $urandom;
    mem_imm         = $urandom;
    mem_auipc       = $urandom;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [2:0] src, input logic [1:0] lo,
                          input logic [1:0] sz, input logic uns);
    rand_inputs();
    mem_valid = 1; mem_reg_write = 1; mem_rd = rd; mem_wb_src = src;
    mem_rdata = 32'h123480FF; mem_addr_lo = lo; mem_ld_size = sz; mem_ld_unsigned = uns;
  endtask

  int         saved_cnt;
  logic [31:0] saved_alu;

  initial begin
    rand_inputs();
    rst_n = 0; stall = 1; flush = 0;
    step(); step();
    check("reset_valid", 64'(wb_valid), 64'd0);
    check("reset_load", 64'(wb_load), 64'd0);
    check("reset_cnt", 64'(retired_cnt), 64'd0);

    rst_n = 1; stall = 0;
    set_load(5'd3, 3'd1, 2'd1, 2'd0, 1'b0);
    step();
    check("byte_load", 64'(wb_load), 64'hFFFFFF80);
    check("byte_sel", 64'(wb_sel), 64'd1);

    set_load(5'd3, 3'd1, 2'd2, 2'd1, 1'b1);
    step();
    check("half_load", 64'(wb_load), 64'h00001234);

    set_load(5'd0, 3'd1, 2'd0, 2'd2, 1'b0);
    step();
    check("rd0_rw", 64'(wb_reg_write), 64'd0);
    check("rd0_ill", 64'(wb_illegal), 64'd0);

    set_load(5'd7, 3'd6, 2'd0, 2'd2, 1'b0);
    step();
    check("src6_rw", 64'(wb_reg_write), 64'd0);
    check("src6_ill", 64'(wb_illegal), 64'd1);
    check("src6_sel", 64'(wb_sel), 64'd0);

    set_load(5'd9, 3'd0, 2'd0, 2'd2, 1'b0);
    step();
    saved_cnt = e_cnt; saved_alu = e_alu;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); mem_valid = 1;
      step();
      check("stall_cnt", 64'(retired_cnt), 64'(saved_cnt));
      check("stall_alu", 64'(wb_alu), 64'(saved_alu));
      check("stall_valid", 64'(wb_valid), 64'd1);
    end
    flush = 1;
    step();
    check("flush_valid", 64'(wb_valid), 64'd0);
    check("flush_cnt", 64'(retired_cnt), 64'(saved_cnt));
    check("flush_alu", 64'(wb_alu), 64'(saved_alu));

    rst_n = 0; stall = 0; flush = 0;
    step();
    rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      rand_inputs(); mem_valid = 1;
      step();
    end
    check("cnt_wrap", 64'(retired_cnt), 64'd1);

    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 49) != 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 4) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
